// File: rtl/enemy_spawner.sv
// Enemy object table: per-frame sweep moves live enemies down, retires those past the bottom,
// and periodically spawns one at a random x/sprite; frame ticks arriving mid-sweep are dropped.
module enemy_spawner #(
    parameter int SLOTS        = 8,
    parameter int SPAWN_PERIOD = 32,
    parameter int SPEED        = 2,
    parameter int SCREEN_H     = 480,
    parameter int X_BASE       = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               rand_byte,
    input  logic                     frame_tick,
    input  logic                     hit_valid,
    input  logic [$clog2(SLOTS)-1:0] hit_slot,
    input  logic [$clog2(SLOTS)-1:0] rd_idx,
    output logic                     rd_active,
    output logic [9:0]               rd_x,
    output logic [9:0]               rd_y,
    output logic [1:0]               rd_sprite,
    output logic                     busy,
    output logic                     escaped,
    output logic                     spawn_drop
);
    localparam int IW = $clog2(SLOTS);
    localparam int CW = $clog2(SPAWN_PERIOD) + 1;

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            due_q, due_d;
    logic            active_q [SLOTS];
    logic            active_d [SLOTS];
    logic [9:0]      x_q      [SLOTS];
    logic [9:0]      x_d      [SLOTS];
    logic [9:0]      y_q      [SLOTS];
    logic [9:0]      y_d      [SLOTS];
    logic [1:0]      spr_q    [SLOTS];
    logic [1:0]      spr_d    [SLOTS];
    logic            rd_active_q, rd_active_d;
    logic [9:0]      rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [1:0]      rd_sprite_q, rd_sprite_d;
    logic            busy_q, busy_d, esc_q, esc_d, drop_q, drop_d;

    logic            free_found;
    logic [IW-1:0]   free_idx;
    logic [10:0]     y_next;
    logic            hit_on_idx;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        due_d    = due_q;
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        spr_d    = spr_q;
        esc_d    = 1'b0;
        drop_d   = 1'b0;

        // Free-slot search deliberately looks at pre-edge state, so a slot freed by a hit
        // on this same edge is not reused until the next spawn.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        y_next     = {1'b0, y_q[idx_q]} + 11'(SPEED);
        hit_on_idx = hit_valid && (hit_slot == idx_q);

        if (hit_valid && active_q[hit_slot]) begin
            active_d[hit_slot] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    if (cnt_q == CW'(SPAWN_PERIOD - 1)) begin
                        cnt_d = '0;
                        due_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        due_d = 1'b0;
                    end
                end
            end
            UPDATE: begin
                if (active_q[idx_q] && !hit_on_idx) begin
                    if (y_next >= 11'(SCREEN_H)) begin
                        active_d[idx_q] = 1'b0;
                        esc_d           = 1'b1;
                    end else begin
                        y_d[idx_q] = y_next[9:0];
                    end
                end
                if (idx_q == IW'(SLOTS - 1)) begin
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SPAWN: begin
                state_d = IDLE;
                if (due_q) begin
                    if (free_found) begin
                        active_d[free_idx] = 1'b1;
                        y_d[free_idx]      = '0;
                        x_d[free_idx]      = 10'(X_BASE) + {1'b0, rand_byte[7:0], 1'b0};
                        spr_d[free_idx]    = rand_byte[9:8];
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rd_active_d = active_q[rd_idx];
        rd_x_d      = x_q[rd_idx];
        rd_y_d      = y_q[rd_idx];
        rd_sprite_d = spr_q[rd_idx];
        // Stays high through the cycle after the SPAWN edge, covering the whole frame sweep.
        busy_d      = (state_d != IDLE) || (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            due_q       <= 1'b0;
            active_q    <= '{default: 1'b0};
            x_q         <= '{default: 10'd0};
            y_q         <= '{default: 10'd0};
            spr_q       <= '{default: 2'd0};
            rd_active_q <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_sprite_q <= '0;
            busy_q      <= 1'b0;
            esc_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            due_q       <= due_d;
            active_q    <= active_d;
            x_q         <= x_d;
            y_q         <= y_d;
            spr_q       <= spr_d;
            rd_active_q <= rd_active_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_sprite_q <= rd_sprite_d;
            busy_q      <= busy_d;
            esc_q       <= esc_d;
            drop_q      <= drop_d;
        end
    end

    assign rd_active  = rd_active_q;
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_sprite  = rd_sprite_q;
    assign busy       = busy_q;
    assign escaped    = esc_q;
    assign spawn_drop = drop_q;
endmodule

// File: tb/tb_enemy_spawner.sv
// Bench for enemy_spawner: default instance for spawn cadence/motion/escape, a SPAWN_PERIOD=1 instance for full-table and hit races.
module tb_enemy_spawner;
    logic clk, rst;

    logic [9:0] rand_a, rand_b;
    logic       tick_a, tick_b, hv_a, hv_b;
    logic [2:0] hs_a, hs_b, ri_a, ri_b;
    logic       ra_a, ra_b, busy_a, busy_b, esc_a, esc_b, drop_a, drop_b;
    logic [9:0] rx_a, rx_b, ry_a, ry_b;
    logic [1:0] rs_a, rs_b;

    enemy_spawner dut_a (
        .clk(clk), .rst(rst), .rand_byte(rand_a), .frame_tick(tick_a),
        .hit_valid(hv_a), .hit_slot(hs_a), .rd_idx(ri_a),
        .rd_active(ra_a), .rd_x(rx_a), .rd_y(ry_a), .rd_sprite(rs_a),
        .busy(busy_a), .escaped(esc_a), .spawn_drop(drop_a)
    );

    enemy_spawner #(.SPAWN_PERIOD(1)) dut_b (
        .clk(clk), .rst(rst), .rand_byte(rand_b), .frame_tick(tick_b),
        .hit_valid(hv_b), .hit_slot(hs_b), .rd_idx(ri_b),
        .rd_active(ra_b), .rd_x(rx_b), .rd_y(ry_b), .rd_sprite(rs_b),
        .busy(busy_b), .escaped(esc_b), .spawn_drop(drop_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       a;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] s;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Push the expected slot contents, issue the read, pop and compare when the registered port answers.
    task automatic rd_check(input bit b, input string tag, input int idx,
                            input logic ea, input int ex, input int ey, input int es);
        rd_exp_t e, got;
        exp_q.push_back('{a: ea, x: 10'(ex), y: 10'(ey), s: 2'(es)});
        if (b) ri_b = 3'(idx); else ri_a = 3'(idx);
        @(posedge clk); #1;
        got = b ? '{a: ra_b, x: rx_b, y: ry_b, s: rs_b} : '{a: ra_a, x: rx_a, y: ry_a, s: rs_a};
        e = exp_q.pop_front();
        check($sformatf("%s.act", tag), 32'(got.a), 32'(e.a));
        if (e.a) begin
            check($sformatf("%s.x", tag), 32'(got.x), 32'(e.x));
            check($sformatf("%s.y", tag), 32'(got.y), 32'(e.y));
            check($sformatf("%s.spr", tag), 32'(got.s), 32'(e.s));
        end
    endtask

    // One frame: tick at E0, then watch 12 cycles. hit_edge/inj_edge name the edge (E1..E11)
    // at which a hit or a stray frame_tick is sampled; 0 disables.
    task automatic frame(input bit b, input int hit_edge, input int hslot, input int inj_edge,
                         output int nb, output int ne, output int nd);
        nb = 0; ne = 0; nd = 0;
        if (b) tick_b = 1'b1; else tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0; tick_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            nb += b ? int'(busy_b) : int'(busy_a);
            ne += b ? int'(esc_b)  : int'(esc_a);
            nd += b ? int'(drop_b) : int'(drop_a);
            if (b) begin
                hv_b = (c + 1 == hit_edge); hs_b = 3'(hslot);
                tick_b = (c + 1 == inj_edge);
            end else begin
                hv_a = (c + 1 == hit_edge); hs_a = 3'(hslot);
                tick_a = (c + 1 == inj_edge);
            end
            @(posedge clk); #1;
        end
        hv_a = 1'b0; hv_b = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    endtask

    function automatic int xb(input int r);
        return 64 + 2 * (r & 8'hFF);
    endfunction

    int nb, ne, nd;
    logic [9:0] rb_tab [1:8];

    initial begin
        rst = 1'b1;
        rand_a = '0; rand_b = '0;
        tick_a = 0; tick_b = 0; hv_a = 0; hv_b = 0;
        hs_a = '0; hs_b = '0; ri_a = '0; ri_b = '0;
        @(posedge clk); #1;
        check("rst.busy", 32'(busy_a), 0);
        check("rst.rd_active", 32'(ra_a), 0);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) rd_check(0, "rst.slot_a", j, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) rd_check(1, "rst.slot_b", j, 0, 0, 0, 0);

        // First spawn lands on tick 32 only.
        rand_a = 10'h3A5;
        for (int t = 1; t <= 336; t++) begin
            frame(0, (t == 336) ? 3 : 0, 2, (t == 100) ? 4 : 0, nb, ne, nd);
            check($sformatf("busy_cycles_t%0d", t), 32'(nb), 10);
            check($sformatf("escaped_t%0d", t), 32'(ne), (t == 272 || t == 304) ? 1 : 0);
            check($sformatf("drop_t%0d", t), 32'(nd), 0);
            if (t < 32) rd_check(0, $sformatf("nospawn_t%0d", t), 0, 0, 0, 0, 0);
            if (t == 32) rd_check(0, "first_spawn", 0, 1, 394, 0, 3);
            if (t == 100) rd_check(0, "ignored_tick_y", 0, 1, 394, 136, 3);
            if (t == 127) rd_check(0, "cadence_pre", 3, 0, 0, 0, 0);
            if (t == 128) rd_check(0, "cadence_spawn", 3, 1, 394, 0, 3);
            if (t == 271) rd_check(0, "bottom_row", 0, 1, 394, 478, 3);
            if (t == 272) rd_check(0, "retired", 0, 0, 0, 0, 0);
            if (t == 335) rd_check(0, "pre_hit_race", 2, 1, 394, 478, 3);
            if (t == 336) rd_check(0, "hit_race_slot2", 2, 0, 0, 0, 0);
        end

        // Full table on the fast-spawn instance.
        for (int k = 1; k <= 8; k++) rb_tab[k] = {2'(k), 8'(k * 29 + 5)};
        for (int k = 1; k <= 8; k++) begin
            rand_b = rb_tab[k];
            frame(1, 0, 0, 0, nb, ne, nd);
            check($sformatf("b_busy_t%0d", k), 32'(nb), 10);
            check($sformatf("b_drop_t%0d", k), 32'(nd), 0);
        end
        for (int j = 0; j < 8; j++)
            rd_check(1, $sformatf("full_slot%0d", j), j, 1, xb(int'(rb_tab[j+1])), 2 * (7 - j), (j + 1) & 3);
        rand_b = 10'h2FF;
        frame(1, 0, 0, 0, nb, ne, nd);
        check("full_drop", 32'(nd), 1);
        check("full_esc", 32'(ne), 0);
        for (int j = 0; j < 8; j++)
            rd_check(1, $sformatf("after_drop_slot%0d", j), j, 1, xb(int'(rb_tab[j+1])), 2 * (8 - j), (j + 1) & 3);

        // Free slots 6 and 7, then hit slot 5 on the SPAWN edge: the spawn must go to 6.
        hv_b = 1'b1; hs_b = 3'd6;
        @(posedge clk); #1;
        hs_b = 3'd7;
        @(posedge clk); #1;
        hv_b = 1'b0;
        rand_b = 10'h155;
        frame(1, 9, 5, 0, nb, ne, nd);
        check("race_drop", 32'(nd), 0);
        rd_check(1, "race_slot4", 4, 1, xb(int'(rb_tab[5])), 10, 1);
        rd_check(1, "race_slot5", 5, 0, 0, 0, 0);
        rd_check(1, "race_slot6", 6, 1, 234, 0, 1);
        rd_check(1, "race_slot7", 7, 0, 0, 0, 0);

        // Reset in the middle of a sweep.
        tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_busy_pre", 32'(busy_a), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_a), 0);
        check("midrst_esc", 32'(esc_a), 0);
        check("midrst_drop", 32'(drop_a), 0);
        check("midrst_rd_active", 32'(ra_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 8; j++) rd_check(0, $sformatf("midrst_slot%0d", j), j, 0, 0, 0, 0);
        frame(0, 0, 0, 0, nb, ne, nd);
        check("midrst_busy_after", 32'(nb), 10);
        rd_check(0, "midrst_no_spawn", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Object-table stage directly downstream of the 10-bit LFSR random source. Once per frame it advances every live enemy down the screen, retires enemies that leave the bottom edge, and every SPAWN_PERIOD frames spawns a new enemy at a random x with a random sprite taken from the random source. The renderer and collision logic read and clear slots through a registered read port and a hit port.

## Interface
- SLOTS, 8: number of enemy slots (power of two, 2..16)
- SPAWN_PERIOD, 32: frames between spawn attempts (≥1)
- SPEED, 2: pixels added to y per frame (1..15)
- SCREEN_H, 480: first y row that counts as off-screen
- X_BASE, 64: x offset added to the random position (X_BASE+510 ≤ 1023)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rand_byte  in  10  random source; [7:0] x position, [9:8] sprite select
- frame_tick  in  1  one-cycle pulse, once per frame (vsync)
- hit_valid  in  1  clear request from collision logic
- hit_slot  in  $clog2(SLOTS)  slot to clear
- rd_idx  in  $clog2(SLOTS)  read-port slot index
- rd_active  out  1  slot rd_idx is live
- rd_x  out  10  slot x
- rd_y  out  10  slot y
- rd_sprite  out  2  slot sprite id
- busy  out  1  frame update in progress
- escaped  out  1  one-cycle pulse: an enemy left the screen bottom
- spawn_drop  out  1  one-cycle pulse: spawn due but all slots full

## Operation
- Per slot: active (1), x (10), y (10), sprite (2). Reset: all active=0, x=y=sprite=0.
- FSM states IDLE, UPDATE, SPAWN. Reset → IDLE.
- IDLE: frame_tick=1 → UPDATE with slot index 0; spawn counter evaluated this edge. frame_tick in UPDATE/SPAWN is ignored (not queued, not counted).
- Spawn counter (width $clog2(SPAWN_PERIOD)+1): reset 0. On each accepted tick: if counter==SPAWN_PERIOD-1 → counter=0, spawn_due=1; else counter+1, spawn_due=0.
- UPDATE, index i (one slot per cycle): if active: if y+SPEED ≥ SCREEN_H (11-bit compare) → active=0, pulse escaped; else y += SPEED. Inactive slots unchanged. i==SLOTS-1 → SPAWN, else i+1.
- SPAWN: if spawn_due: lowest-index inactive slot gets active=1, y=0, x=X_BASE+{rand_byte[7:0],1'b0}, sprite=rand_byte[9:8], rand_byte sampled this cycle; no free slot → pulse spawn_drop, table unchanged. Always → IDLE.
- Hit: hit_valid with active slot hit_slot → active=0 at that edge, any state. Inactive target: no effect.
- Hit vs update same slot same edge: hit wins; slot inactive, no y change, no escaped pulse.
- Hit vs spawn same slot same edge: spawn wins (slot was inactive, hit has no effect).
- Hit on another slot during SPAWN: freed slot is not a spawn candidate this edge (free search uses pre-edge state).

## Timing
- Tick sampled at edge E0; slot i updated at edge E(1+i); spawn at edge E(SLOTS+1); IDLE after it. Total SLOTS+2 cycles per frame.
- busy = (state≠IDLE), registered; high from after E0 through E(SLOTS+1).
- escaped/spawn_drop: registered, high exactly one cycle after the causing edge; reset 0.
- Read port: rd_idx sampled at edge, rd_* valid after that edge and reflecting slot state before it (1-cycle latency). Reset: rd_active=0, rd_x=rd_y=0, rd_sprite=0.
- rst asserted mid-UPDATE/SPAWN: immediately IDLE, table cleared, counter 0, all outputs 0.

## Test plan
- Reset: assert rst mid-UPDATE → busy=0, escaped=0, spawn_drop=0, every rd_idx reads rd_active=0 next cycle.
- First spawn: rand_byte=0x3A5, 32 frame_ticks → after 32nd tick slot 0: active=1, x=394, y=0, sprite=3; no spawn after ticks 1..31; busy high 10 cycles per tick.
- Motion/escape: one enemy spawned at tick 32; after tick 271 rd_y=478; tick 272 → slot inactive, escaped pulses once, one cycle.
- Full table: 8 spawns with no escapes (SPAWN_PERIOD=1 override), 9th tick → spawn_drop pulse, slots 0..7 unchanged.
- Hit race: hit_valid on slot 2 at the edge it would retire → slot 2 inactive, escaped stays 0; hit on slot 5 during SPAWN with slots 0..4 full, 5 active, 6 free → spawn lands in slot 6.
- Ignored tick: frame_tick re-pulsed during UPDATE → no extra y advance, spawn counter unchanged.
